// File: rtl/ysyx_22050612_ifu_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_22050612_ifu_pkg
//
// Shared definitions for the instruction fetch unit:
//   - ifu_state_t      : FSM state encoding (IDLE, FETCH, WAIT_RSP, ISSUE,
//                        WAIT_NPC, ERR)
//   - INST_W, PC_W     : instruction word and program counter widths
//   - DEFAULT_RESET_PC : PC of the first fetch after reset
//   - is_misaligned()  : true when a PC is not 4-byte aligned
//
// The ERR state is only reachable when YSYX_22050612_IFU_MISALIGN_EN is
// defined; the encoding is kept here unconditionally so that every build
// shares one state type.
// -----------------------------------------------------------------------------
package ysyx_22050612_ifu_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 64;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [2:0] {
        IFU_IDLE     = 3'd0,
        IFU_FETCH    = 3'd1,
        IFU_WAIT_RSP = 3'd2,
        IFU_ISSUE    = 3'd3,
        IFU_WAIT_NPC = 3'd4,
        IFU_ERR      = 3'd5
    } ifu_state_t;

    // Instructions are 32-bit words, so the two low PC bits must be zero.
    function automatic logic is_misaligned(input logic [PC_W-1:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_22050612_ifu.sv
// -----------------------------------------------------------------------------
// ysyx_22050612_ifu
//
// Instruction fetch unit. Holds the architectural PC, fetches one instruction
// at a time from instruction memory and hands it (with its PC) to the decoder,
// then waits for the execute unit to return the next PC. Exactly one
// instruction is in flight.
//
// Ports:
//   clk, rst_n       : clock (rising edge) and asynchronous active-low reset
//   imem_req_valid   : fetch request valid (out)
//   imem_req_ready   : memory accepts the request (in)
//   imem_req_addr    : fetch address = PC (out, 64)
//   imem_rsp_valid   : instruction data valid, cannot be backpressured (in)
//   imem_rsp_data    : instruction word (in, 32)
//   inst_valid       : instruction offered to decoder (out)
//   inst_ready       : decoder accepts instruction (in)
//   inst             : instruction word (out, 32)
//   inst_pc          : PC of inst (out, 64)
//   dnpc_valid       : next PC presented by execute (in)
//   dnpc             : next PC (in, 64)
//   fetch_err        : sticky misaligned-PC error (out)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both 1. Once valid is raised, it and its payload stay unchanged
// until that edge; valid never depends combinationally on ready.
// imem_rsp_valid and dnpc_valid are single-sided: they are consumed only in
// WAIT_RSP / WAIT_NPC respectively and ignored in every other state.
//
// Configuration macro: YSYX_22050612_IFU_MISALIGN_EN
//   defined   : a misaligned dnpc sends the FSM to the terminal ERR state,
//               where fetch_err=1 and no further requests are issued.
//   undefined : dnpc is used unchanged and fetch_err is tied to 0.
//
// All outputs come from registers or from decoding the state register; there
// is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module ysyx_22050612_ifu
    import ysyx_22050612_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,

    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,

    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,

    input  logic              dnpc_valid,
    input  logic [PC_W-1:0]   dnpc,

    output logic              fetch_err
);

    ifu_state_t        state_q;
    logic [PC_W-1:0]   pc_q;
    logic [INST_W-1:0] inst_q;
    logic [PC_W-1:0]   inst_pc_q;

    // Single FSM process: state, PC and the instruction/PC hand-off registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IFU_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            case (state_q)
                IFU_IDLE: begin
                    state_q <= IFU_FETCH;
                end

                IFU_FETCH: begin
                    // Request valid is decoded from this state, so the
                    // handshake is simply "ready seen while in FETCH".
                    if (imem_req_ready) begin
                        state_q <= IFU_WAIT_RSP;
                    end
                end

                IFU_WAIT_RSP: begin
                    if (imem_rsp_valid) begin
                        inst_q    <= imem_rsp_data;
                        inst_pc_q <= pc_q;
                        state_q   <= IFU_ISSUE;
                    end
                end

                IFU_ISSUE: begin
                    if (inst_ready) begin
                        state_q <= IFU_WAIT_NPC;
                    end
                end

                IFU_WAIT_NPC: begin
                    if (dnpc_valid) begin
                        // The faulting dnpc is still captured into the PC so
                        // it can be inspected after the error.
                        pc_q <= dnpc;
`ifdef YSYX_22050612_IFU_MISALIGN_EN
                        if (is_misaligned(dnpc)) begin
                            state_q <= IFU_ERR;
                        end else begin
                            state_q <= IFU_FETCH;
                        end
`else
                        state_q <= IFU_FETCH;
`endif
                    end
                end

`ifdef YSYX_22050612_IFU_MISALIGN_EN
                IFU_ERR: begin
                    // Terminal: only reset leaves this state.
                    state_q <= IFU_ERR;
                end
`endif

                default: begin
                    state_q <= IFU_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from the state register. The address is gated so that
    // every output reads 0 in IDLE and while reset is held, even though the
    // PC register itself resets to RESET_PC.
    assign imem_req_valid = (state_q == IFU_FETCH);
    assign imem_req_addr  = (state_q == IFU_FETCH) ? pc_q : '0;
    assign inst_valid     = (state_q == IFU_ISSUE);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;

`ifdef YSYX_22050612_IFU_MISALIGN_EN
    assign fetch_err = (state_q == IFU_ERR);
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// -----------------------------------------------------------------------------
// tb_ysyx_22050612_ifu
//
// Directed testbench for ysyx_22050612_ifu: reset release, zero-wait fetch
// loop, request and issue stalls, spurious inputs, mid-fetch reset and the
// misaligned next-PC case (behaviour selected by YSYX_22050612_IFU_MISALIGN_EN).
// Inputs are driven 1 time unit after the rising edge; outputs are checked at
// that same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_ysyx_22050612_ifu;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        dnpc_valid;
    logic [63:0] dnpc;
    logic        fetch_err;

    int tests_run;
    int tests_failed;

    ysyx_22050612_ifu #(
        .RESET_PC(64'h0000_0000_8000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .dnpc_valid     (dnpc_valid),
        .dnpc           (dnpc),
        .fetch_err      (fetch_err)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; return 1 unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full zero-wait instruction starting in FETCH at pc, ending in FETCH
    // at next_pc. Checks the 4-cycle cadence along the way.
    task automatic zero_wait_instr(input logic [63:0] pc, input logic [31:0] data,
                                   input logic [63:0] next_pc);
        check("zw_req_valid", {63'd0, imem_req_valid}, 64'd1);
        check("zw_req_addr", imem_req_addr, pc);
        imem_req_ready = 1'b1;
        tick();                                     // -> WAIT_RSP
        check("zw_req_drop", {63'd0, imem_req_valid}, 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();                                     // -> ISSUE
        imem_rsp_valid = 1'b0;
        check("zw_inst_valid", {63'd0, inst_valid}, 64'd1);
        check("zw_inst", {32'd0, inst}, {32'd0, data});
        check("zw_inst_pc", inst_pc, pc);
        inst_ready = 1'b1;
        tick();                                     // -> WAIT_NPC
        inst_ready = 1'b0;
        check("zw_inst_valid_drop", {63'd0, inst_valid}, 64'd0);
        dnpc_valid = 1'b1;
        dnpc       = next_pc;
        tick();                                     // -> FETCH
        dnpc_valid = 1'b0;
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        dnpc_valid     = 1'b0;
        dnpc           = '0;

        // ---------------- reset values ----------------
        tick();
        tick();
        check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        check("rst_req_addr", imem_req_addr, 64'd0);
        check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("rst_inst", {32'd0, inst}, 64'd0);
        check("rst_inst_pc", inst_pc, 64'd0);
        check("rst_fetch_err", {63'd0, fetch_err}, 64'd0);

        // ---------------- reset release ----------------
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        #1;
        check("idle_req_valid", {63'd0, imem_req_valid}, 64'd0);
        tick();                                     // IDLE -> FETCH
        check("rel_req_valid", {63'd0, imem_req_valid}, 64'd1);
        check("rel_req_addr", imem_req_addr, 64'h8000_0000);

        // ---------------- zero-wait loop ----------------
        zero_wait_instr(64'h8000_0000, 32'h0000_0013, 64'h8000_0004);
        zero_wait_instr(64'h8000_0004, 32'h0000_0013, 64'h8000_0008);
        check("zw_third_addr", imem_req_addr, 64'h8000_0008);

        // ---------------- request stall ----------------
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_req_valid", {63'd0, imem_req_valid}, 64'd1);
            check("stall_req_addr", imem_req_addr, 64'h8000_0008);
        end
        imem_req_ready = 1'b1;
        tick();                                     // -> WAIT_RSP
        check("stall_one_req", {63'd0, imem_req_valid}, 64'd0);
        tick();                                     // still WAIT_RSP, no rsp
        check("stall_no_second_req", {63'd0, imem_req_valid}, 64'd0);
        check("stall_no_issue", {63'd0, inst_valid}, 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00a0_0093;
        tick();                                     // -> ISSUE
        imem_rsp_valid = 1'b0;

        // ---------------- issue stall + spurious inputs ----------------
        inst_ready = 1'b0;
        dnpc_valid = 1'b1;
        dnpc       = 64'h1234;
        for (int i = 0; i < 5; i++) begin
            imem_rsp_valid = 1'b1;                  // spurious response
            imem_rsp_data  = 32'hdead_beef;
            check("istall_valid", {63'd0, inst_valid}, 64'd1);
            check("istall_inst", {32'd0, inst}, 64'h00a0_0093);
            check("istall_inst_pc", inst_pc, 64'h8000_0008);
            tick();
        end
        imem_rsp_valid = 1'b0;
        check("istall_inst_end", {32'd0, inst}, 64'h00a0_0093);
        dnpc_valid = 1'b0;
        inst_ready = 1'b1;
        tick();                                     // -> WAIT_NPC
        inst_ready = 1'b0;
        check("spur_no_fetch", {63'd0, imem_req_valid}, 64'd0);
        dnpc_valid = 1'b1;
        dnpc       = 64'h8000_0100;
        tick();                                     // -> FETCH
        dnpc_valid = 1'b0;
        check("spur_req_valid", {63'd0, imem_req_valid}, 64'd1);
        check("spur_req_addr", imem_req_addr, 64'h8000_0100);

        // ---------------- mid-fetch reset ----------------
        imem_req_ready = 1'b1;
        tick();                                     // -> WAIT_RSP
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        check("midrst_inst", {32'd0, inst}, 64'd0);
        check("midrst_inst_pc", inst_pc, 64'd0);
        tick();
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;                      // late response, must drop
        imem_rsp_data  = 32'hcafe_f00d;
        tick();                                     // IDLE -> FETCH
        check("midrst_req_valid2", {63'd0, imem_req_valid}, 64'd1);
        check("midrst_req_addr", imem_req_addr, 64'h8000_0000);
        tick();                                     // FETCH held (ready=0)
        imem_rsp_valid = 1'b0;
        check("midrst_rsp_dropped", {32'd0, inst}, 64'd0);
        check("midrst_no_issue", {63'd0, inst_valid}, 64'd0);

        // ---------------- misaligned next PC ----------------
        zero_wait_instr(64'h8000_0000, 32'h0000_0013, 64'h8000_0002);
`ifdef YSYX_22050612_IFU_MISALIGN_EN
        check("mis_err", {63'd0, fetch_err}, 64'd1);
        check("mis_no_req", {63'd0, imem_req_valid}, 64'd0);
        tick();
        tick();
        check("mis_err_sticky", {63'd0, fetch_err}, 64'd1);
        check("mis_no_req_later", {63'd0, imem_req_valid}, 64'd0);
`else
        check("mis_req_valid", {63'd0, imem_req_valid}, 64'd1);
        check("mis_req_addr", imem_req_addr, 64'h8000_0002);
        check("mis_no_err", {63'd0, fetch_err}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ysyx_22050612_ifu.md
# ysyx_22050612_ifu

Instruction fetch unit directly upstream of the decode/execute path. Holds the architectural PC, fetches one 32-bit instruction per step over a valid/ready request/response port to instruction memory, and hands the instruction with its PC to the decoder over a valid/ready handshake. The IFU then waits for the next PC (`dnpc`) from the execute unit before fetching again. Exactly one instruction is in flight at a time.

## Interface
Parameters:
- `RESET_PC`, 64'h8000_0000: PC of the first fetch after reset.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 64: fetch address, equal to the current PC.
- `imem_rsp_valid` in 1: instruction data valid. The IFU cannot backpressure this signal.
- `imem_rsp_data` in 32: instruction word.
- `inst_valid` out 1: an instruction is offered to the decoder.
- `inst_ready` in 1: the decoder accepts the instruction.
- `inst` out 32: the instruction word.
- `inst_pc` out 64: PC of `inst`.
- `dnpc_valid` in 1: the execute unit presents the next PC.
- `dnpc` in 64: next PC.
- `fetch_err` out 1: sticky misaligned-PC error flag (see Configuration).

## Operation
The FSM has five states: IDLE, FETCH, WAIT_RSP, ISSUE, WAIT_NPC.
- **IDLE** (reset state): all outputs are 0. Moves unconditionally to FETCH on the next cycle.
- **FETCH**:
  - `imem_req_valid`=1 and `imem_req_addr`=PC.
  - On `imem_req_valid && imem_req_ready`, move to WAIT_RSP.
  - The address is held stable while `imem_req_ready`=0.
- **WAIT_RSP**:
  - On `imem_rsp_valid`, latch `imem_rsp_data` into the instruction register, latch PC into `inst_pc`, and move to ISSUE.
- **ISSUE**:
  - `inst_valid`=1; `inst` and `inst_pc` are held stable until accepted.
  - On `inst_valid && inst_ready`, move to WAIT_NPC.
- **WAIT_NPC**:
  - On `dnpc_valid`, set PC ← `dnpc` and move to FETCH.

Ignored inputs:
- `imem_rsp_valid` outside WAIT_RSP.
- `dnpc_valid` outside WAIT_NPC.

PC rules:
- The PC is 64 bits and changes only on the WAIT_NPC → FETCH transition.
- No arithmetic is done on the PC; the sequential next PC (`pc+4`) is the execute unit's responsibility.
- `inst` and `inst_pc` keep their last values outside ISSUE; `inst` and `inst_pc` reset to 0.

## Timing
Reset values:
- Every output is 0 while `rst_n`=0.
- PC resets to `RESET_PC`.
- Asserting reset in any state aborts immediately; any outstanding memory response is dropped.

Cycle behaviour:
- First cycle after reset release: IDLE. Second cycle: `imem_req_valid`=1 with address `RESET_PC`.
- Minimum latency per instruction is 4 cycles (FETCH, WAIT_RSP, ISSUE, WAIT_NPC), given zero-wait ready/valid responses. Each stall adds whole cycles.
- `imem_rsp_valid` may arrive no earlier than the cycle after the request handshake.
- All outputs are driven from registers or decoded from the state register only. There is no combinational path from any input to any output.

## Configuration
`YSYX_22050612_IFU_MISALIGN_EN`
- **Defined:**
  - In WAIT_NPC, a `dnpc` with `dnpc[1:0]`≠0 moves the FSM to a terminal state ERR.
  - In ERR: `fetch_err`=1, no further requests are issued, and the PC holds the faulting `dnpc`.
  - Only reset leaves ERR.
- **Undefined:**
  - `dnpc` is used unchanged.
  - `fetch_err` is tied to 0 and the ERR state does not exist.

## Structure
- Package `ysyx_22050612_ifu_pkg` holds:
  - the state enum (IDLE, FETCH, WAIT_RSP, ISSUE, WAIT_NPC, ERR);
  - constants `INST_W`=32, `PC_W`=64, and the default `RESET_PC`.
- No sub-module. The block is a single FSM plus the PC and instruction registers.

## Test plan
- **Reset release:** `rst_n` 0→1 with `imem_req_ready`=1 → `imem_req_valid`=1 and `imem_req_addr`=0x8000_0000 on the second cycle after release.
- **Zero-wait loop:** memory answers 0x0000_0013 one cycle after each request; `inst_ready`=1; `dnpc`=`inst_pc`+4 one cycle after each issue → PCs 0x8000_0000, 0x8000_0004, 0x8000_0008, one instruction every 4 cycles.
- **Stalls:**
  - `imem_req_ready` held low 3 cycles → address is stable and only one request is accepted.
  - `inst_ready` held low 5 cycles → `inst` and `inst_pc` are unchanged throughout.
- **Spurious inputs:** `dnpc_valid`=1 with `dnpc`=0x1234 during ISSUE → ignored; the next fetch address is the `dnpc` given in WAIT_NPC.
- **Mid-fetch reset:** reset asserted in WAIT_RSP, then a response arrives after release → response is ignored; the next request is to 0x8000_0000.
- **Misaligned next PC (macro defined):** `dnpc`=0x8000_0002 → `fetch_err`=1 next cycle, `imem_req_valid` stays 0. With the macro undefined, the request is issued to 0x8000_0002.
